// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: registered N-to-1 word multiplexer with manual select and
// round-robin auto-scan, each output word tagged with its source channel.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (dominates en/mode)
//   d            flattened channel inputs, channel i = d[i*WIDTH +: WIDTH]
//   s            manual channel select (ignored in scan mode)
//   mode         0 = manual (from s), 1 = scan (internal pointer)
//   en           update enable; 0 freezes state and drops result_valid
//   result       registered selected word
//   result_ch    channel index that produced result
//   result_valid one-cycle strobe: result is a fresh in-range sample
module mux_nx1_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 1,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          s,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          result,
  output logic [SEL_W-1:0]          result_ch,
  output logic                      result_valid
);

  localparam int unsigned DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0]  result_q, result_d;
  logic [SEL_W-1:0]  result_ch_q, result_ch_d;
  logic              result_valid_q, result_valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  logic [WIDTH-1:0]  man_word;
  logic              man_hit;
  logic [WIDTH-1:0]  scan_word;

  // Channel lookup by compare so an out-of-range s never indexes past d.
  always_comb begin
    man_word  = '0;
    man_hit   = 1'b0;
    scan_word = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (s == SEL_W'(i)) begin
        man_word = d[i*WIDTH +: WIDTH];
        man_hit  = 1'b1;
      end
      if (ptr_q == SEL_W'(i)) begin
        scan_word = d[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: hold everything by default, valid is a strobe.
  always_comb begin
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_valid_d = 1'b0;
    ptr_d          = ptr_q;
    dcnt_d         = dcnt_q;

    if (en) begin
      if (!mode) begin
        result_d       = man_hit ? man_word : '0;
        result_ch_d    = s;
        result_valid_d = man_hit;
        // Park the scan pointer so every scan entry starts at channel 0.
        ptr_d          = '0;
        dcnt_d         = '0;
      end else begin
        result_d       = scan_word;
        result_ch_d    = ptr_q;
        result_valid_d = 1'b1;
        // Explicit compare-and-clear wrap for non-power-of-2 counts.
        if (dcnt_q == DCNT_W'(DWELL - 1)) begin
          dcnt_d = '0;
          ptr_d  = (ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : ptr_q + SEL_W'(1);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      ptr_q          <= '0;
      dcnt_q         <= '0;
    end else begin
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      ptr_q          <= ptr_d;
      dcnt_q         <= dcnt_d;
    end
  end

  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Testbench for mux_nx1_reg: a 4-channel and a 3-channel instance (DWELL=2)
// share stimulus; a behavioural model queues expected outputs and a monitor
// compares them on the falling edge.
module tb_mux_nx1_reg;

  localparam int unsigned DWELL = 2;

  typedef struct packed {
    logic [7:0] res;
    logic [1:0] ch;
    logic       v;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  s;
  logic [31:0] d;
  logic [23:0] d3;

  logic [7:0]  r0, r1;
  logic [1:0]  ch0, ch1;
  logic        v0, v1;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  // Model state per instance: last word/channel and count of scan cycles
  // since the last scan entry (channel = (count / DWELL) mod CHANNELS).
  logic [7:0]  m_res [2];
  logic [1:0]  m_ch  [2];
  int unsigned m_cnt [2];

  assign d3 = d[23:0];

  mux_nx1_reg #(.WIDTH(8), .CHANNELS(4), .DWELL(DWELL)) dut4 (
    .clk(clk), .rst(rst), .d(d), .s(s), .mode(mode), .en(en),
    .result(r0), .result_ch(ch0), .result_valid(v0)
  );

  mux_nx1_reg #(.WIDTH(8), .CHANNELS(3), .DWELL(DWELL)) dut3 (
    .clk(clk), .rst(rst), .d(d3), .s(s), .mode(mode), .en(en),
    .result(r1), .result_ch(ch1), .result_valid(v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict both instances, then cross the edge.
  task automatic apply(input logic r, input logic e, input logic m,
                       input logic [1:0] sel, input logic [31:0] dv);
    int unsigned chs;
    int unsigned c;
    exp_t x;
    rst = r; en = e; mode = m; s = sel; d = dv;
    for (int k = 0; k < 2; k++) begin
      chs = (k == 0) ? 4 : 3;
      x.v = 1'b0;
      if (r) begin
        m_res[k] = 8'h00;
        m_ch[k]  = 2'd0;
        m_cnt[k] = 0;
      end else if (e && !m) begin
        m_cnt[k] = 0;
        m_ch[k]  = sel;
        if (int'(sel) < int'(chs)) begin
          m_res[k] = dv[sel*8 +: 8];
          x.v      = 1'b1;
        end else begin
          m_res[k] = 8'h00;
        end
      end else if (e && m) begin
        c        = (m_cnt[k] / DWELL) % chs;
        m_res[k] = dv[c*8 +: 8];
        m_ch[k]  = 2'(c);
        x.v      = 1'b1;
        m_cnt[k] = m_cnt[k] + 1;
      end
      x.res = m_res[k];
      x.ch  = m_ch[k];
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle presents one registered output word per instance.
  always @(negedge clk) begin
    exp_t e0;
    exp_t e1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      checks++;
      if ({r0, ch0, v0} !== e0) begin
        errors++;
        $display("FAIL ch4 @%0t: got res=%h ch=%0d v=%b, want res=%h ch=%0d v=%b",
                 $time, r0, ch0, v0, e0.res, e0.ch, e0.v);
      end
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      checks++;
      if ({r1, ch1, v1} !== e1) begin
        errors++;
        $display("FAIL ch3 @%0t: got res=%h ch=%0d v=%b, want res=%h ch=%0d v=%b",
                 $time, r1, ch1, v1, e1.res, e1.ch, e1.v);
      end
    end
  end

  localparam logic [31:0] DPAT = 32'hDDCCBBAA;

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; s = 2'd0; d = '0;

    // Reset with en/mode asserted
    apply(1, 1, 1, 2'd0, DPAT);
    apply(1, 1, 1, 2'd0, DPAT);

    // Manual sweep
    for (int i = 0; i < 4; i++) apply(0, 1, 0, 2'(i), DPAT);

    // Enable hold then re-enable
    apply(0, 1, 0, 2'd2, DPAT);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 2'd1, DPAT);
    apply(0, 1, 0, 2'd1, DPAT);

    // Scan rotation
    apply(0, 1, 0, 2'd0, DPAT);
    for (int i = 0; i < 9; i++) apply(0, 1, 1, 2'd3, DPAT);

    // Scan with gaps and mode re-entry
    apply(0, 1, 0, 2'd0, DPAT);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 2'd0, DPAT);
    apply(0, 0, 1, 2'd0, DPAT);
    apply(0, 0, 1, 2'd0, DPAT);
    apply(0, 1, 1, 2'd0, DPAT);
    apply(0, 1, 1, 2'd0, DPAT);
    apply(0, 1, 0, 2'd3, DPAT);
    apply(0, 1, 1, 2'd0, DPAT);
    apply(0, 1, 1, 2'd0, DPAT);

    // Out-of-range select on the 3-channel instance
    apply(0, 1, 0, 2'd3, DPAT);

    // Reset mid-scan while on channel 2, then restart
    apply(0, 1, 0, 2'd0, DPAT);
    for (int i = 0; i < 5; i++) apply(0, 1, 1, 2'd0, DPAT);
    apply(1, 1, 1, 2'd0, DPAT);
    for (int i = 0; i < 4; i++) apply(0, 1, 1, 2'd0, DPAT);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            32'($urandom));
    end

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
